// File: rtl/vip_color_pkg.sv
// Shared colour-space constants for the VIP pixel pipelines (YCbCr<->RGB).
// Coefficients are 8-bit fixed point (x256); offsets already fold in the 128 chroma bias.
package vip_color_pkg;

    localparam int PIPE_DEPTH = 3;
    localparam int SUM_W      = 20;
    localparam int FRAC_BITS  = 8;
    localparam int ROUND_HALF = 128;
    localparam int NUM_CH     = 3;

    // YCbCr444 -> RGB888
    localparam int K_Y    = 256;
    localparam int K_CR_R = 359;
    localparam int K_CB_G = 88;
    localparam int K_CR_G = 183;
    localparam int K_CB_B = 454;
    localparam int OFF_R  = -45952;
    localparam int OFF_G  = 34688;
    localparam int OFF_B  = -58112;

    // RGB888 -> YCbCr444
    localparam int K_R_Y    = 77;
    localparam int K_G_Y    = 150;
    localparam int K_B_Y    = 29;
    localparam int K_R_CB   = 43;
    localparam int K_G_CB   = 85;
    localparam int K_B_CB   = 128;
    localparam int K_R_CR   = 128;
    localparam int K_G_CR   = 107;
    localparam int K_B_CR   = 21;
    localparam int OFF_CBCR = 32768;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    // Every channel is 256*Y + kcb*Cb + kcr*Cr + off, so one datapath serves all three.
    function automatic int cb_coef(input int ch);
        case (ch)
            1:       return -K_CB_G;
            2:       return K_CB_B;
            default: return 0;
        endcase
    endfunction

    function automatic int cr_coef(input int ch);
        case (ch)
            0:       return K_CR_R;
            1:       return -K_CR_G;
            default: return 0;
        endcase
    endfunction

    function automatic int ch_offset(input int ch);
        case (ch)
            0:       return OFF_R;
            1:       return OFF_G;
            default: return OFF_B;
        endcase
    endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// Fixed-depth shift register for frame sync strobes; async active-low clear.
// dout_early is the tap one stage before dout, used to qualify the last data stage.
module vip_sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_early
);

    logic [DEPTH:1][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[1] <= din;
            for (int i = 2; i <= DEPTH; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign dout       = pipe[DEPTH];
    assign dout_early = pipe[DEPTH-1];

endmodule

// File: rtl/vip_ycbcr444_rgb888.sv
// YCbCr444 -> RGB888, 3-stage free-running pipeline (products, sums, shift+fold).
// Build macro VIP_YCBCR2RGB_SAT_EN: clamp to 0..255; otherwise keep the low 8 bits.
module vip_ycbcr444_rgb888
    import vip_color_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_href,
    input  logic       pre_frame_clken,
    input  logic [7:0] pre_img_Y,
    input  logic [7:0] pre_img_Cb,
    input  logic [7:0] pre_img_Cr,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    logic [2:0] sync_out;
    logic [2:0] sync_early;
    logic [NUM_CH-1:0][7:0] rgb;

    vip_sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DEPTH)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        ({pre_frame_vsync, pre_frame_href, pre_frame_clken}),
        .dout       (sync_out),
        .dout_early (sync_early)
    );

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            localparam int KCB = cb_coef(c);
            localparam int KCR = cr_coef(c);
            localparam int OFS = ch_offset(c) + ROUND_HALF;

            logic signed [SUM_W-1:0] p_y, p_cb, p_cr, sum, sh;
            logic [7:0] pix, pix_q;
            logic       unused_bits;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_y   <= '0;
                    p_cb  <= '0;
                    p_cr  <= '0;
                    sum   <= '0;
                    pix_q <= '0;
                end else begin
                    p_y  <= SUM_W'(int'(pre_img_Y) * K_Y);
                    p_cb <= SUM_W'(int'(pre_img_Cb) * KCB);
                    p_cr <= SUM_W'(int'(pre_img_Cr) * KCR);
                    sum  <= p_y + p_cb + p_cr + SUM_W'(OFS);
                    // Result only moves when the sample it belongs to was a real pixel.
                    if (sync_early[0])
                        pix_q <= pix;
                end
            end

            assign sh = sum >>> FRAC_BITS;

            always_comb begin
                pix = sh[7:0];
`ifdef VIP_YCBCR2RGB_SAT_EN
                if (sh < 0)
                    pix = 8'h00;
                else if (sh > 255)
                    pix = 8'hff;
`endif
            end

            // Fraction bits and (in the wrap build) the sign/overflow bits are discarded by design.
            assign unused_bits = ^{sum[FRAC_BITS-1:0], sh};
            assign rgb[c]      = pix_q;
        end
    endgenerate

    logic unused_sync;
    assign unused_sync = ^sync_early[2:1];

    assign post_frame_vsync = sync_out[2];
    assign post_frame_href  = sync_out[1];
    assign post_frame_clken = sync_out[0];
    assign post_img_red     = rgb[CH_R];
    assign post_img_green   = rgb[CH_G];
    assign post_img_blue    = rgb[CH_B];

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Directed + random check of vip_ycbcr444_rgb888: scoreboard of RGB results and 3-clk sync alignment.
module tb_vip_ycbcr444_rgb888;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] y = '0, cb = '0, cr = '0;
    logic       o_vsync, o_href, o_clken;
    logic [7:0] o_r, o_g, o_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic [23:0]      sb[$];
    logic [2:0][2:0]  sh = '0;
    logic [23:0]      last = '0;

    always #5 clk = ~clk;

    vip_ycbcr444_rgb888 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (vsync),
        .pre_frame_href   (href),
        .pre_frame_clken  (clken),
        .pre_img_Y        (y),
        .pre_img_Cb       (cb),
        .pre_img_Cr       (cr),
        .post_frame_vsync (o_vsync),
        .post_frame_href  (o_href),
        .post_frame_clken (o_clken),
        .post_img_red     (o_r),
        .post_img_green   (o_g),
        .post_img_blue    (o_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Floor-divide by 256, then clamp or wrap into a byte.
    function automatic logic [7:0] fold(input int num);
        int q;
        q = (num >= 0) ? num / 256 : -((-num + 255) / 256);
`ifdef VIP_YCBCR2RGB_SAT_EN
        if (q < 0)   return 8'd0;
        if (q > 255) return 8'd255;
`endif
        return 8'(((q % 256) + 256) % 256);
    endfunction

    function automatic logic [23:0] model(input int yy, input int bb, input int rr);
        return {fold(256*yy + 359*rr - 45952 + 128),
                fold(256*yy - 88*bb - 183*rr + 34688 + 128),
                fold(256*yy + 454*bb - 58112 + 128)};
    endfunction

    task automatic tick();
        logic [23:0] exp;
        @(posedge clk);
        if (!rst_n) sh = '0;
        else        sh = {sh[1:0], {vsync, href, clken}};
        #1;
        chk("sync", {29'd0, o_vsync, o_href, o_clken}, {29'd0, sh[2]});
        if (sh[2][0]) begin
            exp  = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
            last = exp;
        end
        chk("rgb", {8'd0, o_r, o_g, o_b}, {8'd0, last});
    endtask

    task automatic px(input logic v, input logic h, input logic c,
                      input logic [7:0] yy, input logic [7:0] bb, input logic [7:0] rr,
                      input logic [23:0] exp);
        vsync = v; href = h; clken = c; y = yy; cb = bb; cr = rr;
        if (c && rst_n) sb.push_back(exp);
        tick();
    endtask

    initial begin
        logic [7:0] ry, rb, rr;
        logic       rc;

        #3;
        chk("reset_rgb",  {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("reset_sync", {29'd0, o_vsync, o_href, o_clken}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        px(1, 0, 0, 8'd0, 8'd0, 8'd0, 24'd0);
        px(1, 0, 0, 8'd0, 8'd0, 8'd0, 24'd0);
        px(0, 0, 0, 8'd0, 8'd0, 8'd0, 24'd0);

        // Directed corner pixels, back to back.
        px(0, 1, 1, 8'd128, 8'd128, 8'd128, {8'd128, 8'd128, 8'd128});
        px(0, 1, 1, 8'd76,  8'd85,  8'd255, {8'd254, 8'd0,   8'd0});
`ifdef VIP_YCBCR2RGB_SAT_EN
        px(0, 1, 1, 8'd255, 8'd128, 8'd255, {8'd255, 8'd164, 8'd255});
        px(0, 1, 1, 8'd0,   8'd0,   8'd0,   {8'd0,   8'd136, 8'd0});
`else
        px(0, 1, 1, 8'd255, 8'd128, 8'd255, {8'd177, 8'd164, 8'd255});
        px(0, 1, 1, 8'd0,   8'd0,   8'd0,   {8'd77,  8'd136, 8'd29});
`endif
        // clken low with changing data: result must hold.
        px(0, 1, 0, 8'd200, 8'd10, 8'd20, 24'd0);
        px(0, 1, 0, 8'd50,  8'd99, 8'd7,  24'd0);
        px(0, 1, 1, 8'd255, 8'd255, 8'd0, model(255, 255, 0));
        px(0, 0, 0, 8'd0,   8'd0,   8'd0, 24'd0);

        for (int i = 0; i < 40; i++) begin
            ry = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            rc = ($urandom_range(0, 3) != 0);
            px(1'b0, 1'b1, rc, ry, rb, rr, model(int'(ry), int'(rb), int'(rr)));
        end
        for (int i = 0; i < 4; i++) px(0, 0, 0, 8'd0, 8'd0, 8'd0, 24'd0);

        // 4-pixel burst with reset asserted just after the 2nd pixel is sampled.
        px(0, 1, 1, 8'd10, 8'd20, 8'd30, model(10, 20, 30));
        vsync = 1'b0; href = 1'b1; clken = 1'b1; y = 8'd90; cb = 8'd60; cr = 8'd200;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rgb",  {8'd0, o_r, o_g, o_b}, 32'd0);
        chk("midreset_sync", {29'd0, o_vsync, o_href, o_clken}, 32'd0);
        sb.delete();
        sh   = '0;
        last = '0;
        px(0, 1, 1, 8'd140, 8'd100, 8'd50, 24'd0);
        rst_n = 1'b1;
        px(0, 1, 1, 8'd33,  8'd222, 8'd111, model(33, 222, 111));
        px(0, 1, 1, 8'd240, 8'd16,  8'd16,  model(240, 16, 16));
        px(1, 0, 0, 8'd0,   8'd0,   8'd0,   24'd0);
        for (int i = 0; i < 4; i++) px(0, 0, 0, 8'd0, 8'd0, 8'd0, 24'd0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
